// File: rtl/wb_sram_resp.sv
// wb_sram_resp: Wishbone classic slave that fronts a single-port SRAM macro.
// Accepts one transfer at a time, maps in-window addresses onto SRAM words,
// and answers out-of-window addresses with an error pulse without touching
// the memory. Every output is driven straight from a flop.
//
// Handshake: a request is cyc&stb sampled at a rising edge while IDLE; its
// completion is a single-cycle pulse on wbs_ack_o (write/read) or wbs_err_o
// (address miss). After any completion the FSM spends one cycle in ACK, where
// stb is ignored, so a master that keeps stb up for one edge past the pulse
// is not accepted twice. Dropping cyc during a read abandons it silently.
module wb_sram_resp #(
    parameter int unsigned AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          wbs_clk_i,
    input  logic          wbs_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic          wbs_we_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [3:0]    wbs_sel_i,
    output logic [31:0]   wbs_dat_o,
    output logic          wbs_ack_o,
    output logic          wbs_err_o,
    output logic          mem_csb_o,
    output logic          mem_web_o,
    output logic [3:0]    mem_wmask_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_din_o,
    input  logic [31:0]   mem_dout_i,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_ACK   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Counter preload: the RD cycle itself accounts for one cycle of latency.
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   dat_q, dat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   din_q, din_d;

    logic req;
    logic addr_hit;
    logic adr_unused;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign addr_hit = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    // Byte-lane bits of the address carry no information for word accesses.
    assign adr_unused = ^wbs_adr_i[1:0];

    // Next-state and registered-output decode; idle memory pins by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = 4'h0;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!addr_hit) begin
                        state_d = S_ERR;
                    end else if (wbs_we_i) begin
                        // Write is presented to the SRAM and acked in the
                        // same cycle; an all-zero mask skips the macro.
                        state_d = S_WR;
                        csb_d   = (wbs_sel_i == 4'h0);
                        web_d   = 1'b0;
                        wmask_d = wbs_sel_i;
                        addr_d  = wbs_adr_i[AW+1:2];
                        din_d   = wbs_dat_i;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = S_RD;
                        csb_d   = 1'b0;
                        addr_d  = wbs_adr_i[AW+1:2];
                    end
                end
            end

            S_WR: begin
                state_d = S_ACK;
            end

            S_RD: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = S_RWAIT;
                    cnt_d   = LAT_LOAD;
                end
            end

            S_RWAIT: begin
                if (!wbs_cyc_i) begin
                    // Abandoned read: no ack and read data left untouched.
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd0) begin
                    dat_d   = mem_dout_i;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_ACK;
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and output registers; reset forces idle pins without a clock.
    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            dat_q   <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'h0;
            addr_q  <= '0;
            din_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign wbs_dat_o   = dat_q;
    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign mem_csb_o   = csb_q;
    assign mem_web_o   = web_q;
    assign mem_wmask_o = wmask_q;
    assign mem_addr_o  = addr_q;
    assign mem_din_o   = din_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/wb_sram_resp.md
# wb_sram_resp

Wishbone responder on the user-area side of the asynchronous Wishbone bridge. It takes single Wishbone classic transfers on the `wbs_*` slave bus and turns them into accesses to a single-port SRAM macro: chip-select and write-enable are active-low, the byte write-mask is active-high, and read data arrives a fixed number of cycles after the access. Addresses outside the block's window complete with an error and never touch the memory.

## Interface
- `AW`, 8: SRAM word-address width; depth is 2^AW 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: window base. Bits [31:AW+2] are compared; lower bits are ignored.
- `RD_LAT`, 1: cycles from the `mem_csb_o` assertion cycle to valid `mem_dout_i`. Legal range is 1–7.
- `wbs_clk_i`, in, 1: block clock. One clock domain only.
- `wbs_rst_i`, in, 1: reset, asynchronous, active-high.
- `wbs_cyc_i`, in, 1: bus cycle valid.
- `wbs_stb_i`, in, 1: transfer strobe.
- `wbs_adr_i`, in, 32: byte address. Word index is [AW+1:2].
- `wbs_we_i`, in, 1: 1 = write.
- `wbs_dat_i`, in, 32: write data.
- `wbs_sel_i`, in, 4: byte enables.
- `wbs_dat_o`, out, 32: read data, registered.
- `wbs_ack_o`, out, 1: transfer done, registered, one-cycle pulse.
- `wbs_err_o`, out, 1: address error, registered, one-cycle pulse.
- `mem_csb_o`, out, 1: SRAM chip select, active-low.
- `mem_web_o`, out, 1: SRAM write enable, active-low.
- `mem_wmask_o`, out, 4: byte write mask.
- `mem_addr_o`, out, AW: word address.
- `mem_din_o`, out, 32: SRAM write data.
- `mem_dout_i`, in, 32: SRAM read data.

## Operation
- **FSM states:** IDLE, WR, RD, RWAIT, ACK, ERR. All outputs come from flops.
- **IDLE**
  - A request is `cyc&stb` sampled at a rising edge. The other inputs are captured at that same edge.
  - Address miss, i.e. `adr[31:AW+2] != BASE_ADDR[31:AW+2]`: go to ERR. No memory access.
  - Hit with `we=1`: go to WR.
  - Hit with `we=0`: go to RD.
- **WR** (one cycle)
  - Drive `mem_csb_o=0`, `mem_web_o=0`, `mem_wmask_o=sel`.
  - `mem_addr_o` and `mem_din_o` hold the captured values.
  - `wbs_ack_o=1` in this same cycle. Next state is ACK.
  - If `sel==4'h0`: `mem_csb_o` stays 1, and ack is still given.
- **RD** (one cycle)
  - Drive `mem_csb_o=0`, `mem_web_o=1`.
  - Load the latency counter with `RD_LAT-1`, then go to RWAIT.
- **RWAIT**
  - Count down to 0.
  - At 0: capture `mem_dout_i` into `wbs_dat_o`, set `wbs_ack_o` for the next cycle, go to ACK.
- **ACK / ERR** (one cycle each)
  - The strobe pulse is high. The FSM ignores `stb` in this cycle and returns to IDLE.
  - This guarantees a held strobe is not re-accepted after the master sees ack or err.
- **Abort:** if `cyc_i` falls while in RD or RWAIT:
  - return to IDLE at the next edge with no ack;
  - `wbs_dat_o` is not updated.
  - A WR in progress completes, because it is a single cycle.
- **Idle memory outputs:** `mem_csb_o=1`, `mem_web_o=1`, `mem_wmask_o=0`. `mem_addr_o` and `mem_din_o` hold their last values.
- `wbs_dat_o` holds the last read data until the next read completes. Writes and errors leave it unchanged.
- `wbs_ack_o` and `wbs_err_o` are never high together.

## Timing
- **Reset values:** `wbs_dat_o=0`, `wbs_ack_o=0`, `wbs_err_o=0`, `mem_csb_o=1`, `mem_web_o=1`, `mem_wmask_o=0`, `mem_addr_o=0`, `mem_din_o=0`. State is IDLE and the counter is 0.
- **Reset mid-transfer:** asserting `wbs_rst_i` forces the reset values immediately, with no clock needed. A pending ack is lost. The first request is sampled at the first edge after deassertion.
- **Write:** request sampled at edge N; ack and memory write are high in cycle N..N+1. The SRAM latches at edge N+1.
- **Error:** request sampled at edge N; `wbs_err_o` is high in cycle N+1..N+2.
- **Read:** request sampled at edge N; `csb` is low in cycle N+1.
  - Data is captured at edge N+1+RD_LAT.
  - Ack is high in cycle N+1+RD_LAT..N+2+RD_LAT.
  - With RD_LAT=1: ack is high 2 cycles after the sampling edge.
- **Back-to-back:** the minimum spacing between successive sampled requests is 3 edges for writes and errors, and RD_LAT+3 for reads.

## Test plan
- **Reset:** assert `wbs_rst_i` mid-read (during RWAIT) -> all outputs return to reset values with no clock; after release, the next read acks normally.
- **Byte-masked write:**
  - write `adr=0x0000_0010`, `dat=0xA5A5_1234`, `sel=4'b0101` -> one cycle with `mem_csb_o=0`, `mem_web_o=0`, `mem_wmask_o=4'b0101`, `mem_addr_o=4`, `mem_din_o=0xA5A5_1234`;
  - ack is a single pulse in that same cycle.
- **Read with latency:** RD_LAT=2, read `adr=0x0000_0010`, memory model returns `0xDEAD_BEEF` -> ack in the 4th cycle after the sampling edge with `wbs_dat_o=0xDEAD_BEEF`; `wbs_dat_o` is still `0xDEAD_BEEF` after a following write.
- **Out of window:** `BASE_ADDR=0x3000_0000`, AW=8, access `0x3000_0400` -> `wbs_err_o` pulses for 1 cycle, `wbs_ack_o=0`, `mem_csb_o` stays 1.
- **Held strobe:** master holds `stb`/`cyc` high for 3 cycles after ack -> exactly one memory access per accepted request; the spacing rule above is met.
- **Abort:** read with `cyc_i` dropped one cycle after `csb` -> no ack, no err, `wbs_dat_o` unchanged, FSM accepts a new write 1 cycle later. A `sel=0` write acks with `mem_csb_o=1` throughout.
